// File: rtl/dmem_pkg.sv
// +----------------------------------------------------------------------------+
// | dmem_pkg : store-size encodings and lane helper for the data-memory path.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  function automatic int lane_log2(input int data_w);
    return (data_w == 64) ? 3 : 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_lane_align.sv
// +----------------------------------------------------------------------------+
// | store_lane_align : byte enables, lane-shifted data and alignment check.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module store_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int BE_W  = DATA_W / 8,
  localparam int OFF_W = lane_log2(DATA_W)
) (
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  offset,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] wdata_out,
  output logic              misaligned
);

  logic [BE_W-1:0]   lane_mask;
  logic [DATA_W-1:0] data_mask;

  always_comb begin
    lane_mask  = '0;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: lane_mask = BE_W'(1'b1);
      SZ_HALF: begin
        lane_mask  = BE_W'(2'b11);
        misaligned = offset[0];
      end
      SZ_WORD: begin
        lane_mask  = BE_W'(4'hF);
        misaligned = |offset[1:0];
      end
      SZ_DWORD: begin
        // Double stores only exist on a 64-bit data path.
        lane_mask  = '1;
        misaligned = (DATA_W != 64) || (|offset);
      end
      default: lane_mask = '0;
    endcase
  end

  for (genvar i = 0; i < BE_W; i++) begin : g_mask
    assign data_mask[8*i +: 8] = {8{lane_mask[i]}};
  end

  assign be        = lane_mask << offset;
  assign wdata_out = (wdata_in & data_mask) << {offset, 3'b000};

endmodule

`default_nettype wire

// File: rtl/dmem_store_buffer.sv
// +----------------------------------------------------------------------------+
// | dmem_store_buffer : in-order store FIFO to data memory with hazard check.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  localparam int BE_W  = DATA_W / 8,
  localparam int OFF_W = lane_log2(DATA_W),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_wdata,
  output logic              st_align_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [BE_W-1:0]   ld_be,
  output logic              ld_hazard,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

  logic [BE_W-1:0]   new_be;
  logic [DATA_W-1:0] new_wdata;
  logic              misaligned;
  logic [ADDR_W-1:0] new_addr;
  logic [ADDR_W-1:0] ld_line;
  logic              take;
  logic              push;
  logic              pop;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DEPTH-1:0]  vld;
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [BE_W-1:0]   be_q    [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];

  store_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .size       (st_size),
    .offset     (st_addr[OFF_W-1:0]),
    .wdata_in   (st_wdata),
    .be         (new_be),
    .wdata_out  (new_wdata),
    .misaligned (misaligned)
  );

  assign new_addr  = st_addr & LINE_MASK;
  assign ld_line   = ld_addr & LINE_MASK;
  assign st_ready  = (count != CNT_W'(DEPTH));
  assign mem_valid = (count != '0);
  assign take      = st_valid && st_ready;
  assign push      = take && !misaligned;
  assign pop       = mem_valid && mem_ready;

  assign mem_addr  = addr_q[rd_ptr];
  assign mem_be    = be_q[rd_ptr];
  assign mem_wdata = wdata_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      vld          <= '0;
      st_align_err <= 1'b0;
    end else begin
      st_align_err <= take && misaligned;
      // Push never targets the head slot while popping: that needs full or empty.
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr]  <= new_addr;
      be_q[wr_ptr]    <= new_be;
      wdata_q[wr_ptr] <= new_wdata;
    end
  end

  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (addr_q[i] == ld_line) && (|(be_q[i] & ld_be))) begin
        ld_hazard = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
// +----------------------------------------------------------------------------+
// | tb_dmem_store_buffer : directed and random stimulus against a queue model. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dmem_store_buffer;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          st_valid;
  logic          st_ready;
  logic [1:0]    st_size;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_wdata;
  logic          st_align_err;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] ld_addr;
  logic [3:0]    ld_be;
  logic          ld_hazard;
  logic [2:0]    count;

  always #5 clk = ~clk;

  dmem_store_buffer #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_size      (st_size),
    .st_addr      (st_addr),
    .st_wdata     (st_wdata),
    .st_align_err (st_align_err),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .ld_addr      (ld_addr),
    .ld_be        (ld_be),
    .ld_hazard    (ld_hazard),
    .count        (count)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   exp_err    = 1'b0;
  bit   last_acc   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected buffer entry derived directly from size/address arithmetic.
  function automatic ent_t make_entry(input logic [1:0] sz, input logic [31:0] a,
                                      input logic [31:0] wd, output bit legal);
    int          nb;
    int          off;
    logic [63:0] m;
    ent_t        e;
    nb     = 1 << sz;
    off    = int'(a[1:0]);
    legal  = (sz != 2'd3) && ((off % nb) == 0);
    m      = (nb >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    e.addr = a - 32'(off);
    e.be   = 4'(((1 << nb) - 1) << off);
    e.data = 32'(({32'd0, wd} & m) << (8 * off));
    return e;
  endfunction

  function automatic bit ref_hazard();
    foreach (q[i]) begin
      if (q[i].addr == {ld_addr[31:2], 2'b00} && (q[i].be & ld_be) != 4'b0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_state();
    chk("count", 64'(count), 64'(q.size()));
    chk("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
    chk("st_ready", 64'(st_ready), 64'(q.size() < DEPTH));
    chk("st_align_err", 64'(st_align_err), 64'(exp_err));
    chk("ld_hazard", 64'(ld_hazard), 64'(ref_hazard()));
    if (q.size() != 0) begin
      chk("mem_addr", 64'(mem_addr), 64'(q[0].addr));
      chk("mem_be", 64'(mem_be), 64'(q[0].be));
      chk("mem_wdata", 64'(mem_wdata), 64'(q[0].data));
    end
  endtask

  task automatic tick();
    ent_t e;
    bit   legal;
    bit   acc;
    bit   pop;
    e   = make_entry(st_size, st_addr, st_wdata, legal);
    acc = st_valid && (q.size() < DEPTH);
    pop = (q.size() != 0) && mem_ready;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (acc && legal) q.push_back(e);
    exp_err  = acc && !legal;
    last_acc = acc;
    #1;
    check_state();
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_wdata = d;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    mem_ready = 1'b1;
    while (q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
    mem_ready = 1'b0;
  endtask

  initial begin
    int n;
    st_valid  = 1'b0;
    st_size   = 2'b00;
    st_addr   = '0;
    st_wdata  = '0;
    mem_ready = 1'b0;
    ld_addr   = '0;
    ld_be     = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_mem_valid", 64'(mem_valid), 64'd0);
    chk("reset_align_err", 64'(st_align_err), 64'd0);
    chk("reset_hazard", 64'(ld_hazard), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_st_ready", 64'(st_ready), 64'd1);
    check_state();

    store(2'b00, 32'h1003, 32'h0000_00AB);
    chk("sb_addr", 64'(mem_addr), 64'h1000);
    chk("sb_be", 64'(mem_be), 64'b1000);
    chk("sb_wdata", 64'(mem_wdata), 64'hAB00_0000);
    drain();

    store(2'b01, 32'h2001, 32'h0000_1234);
    chk("sh_mis_err", 64'(st_align_err), 64'd1);
    chk("sh_mis_count", 64'(count), 64'd0);
    tick();
    chk("sh_mis_pulse_end", 64'(st_align_err), 64'd0);
    store(2'b01, 32'h2002, 32'h0000_1234);
    chk("sh_be", 64'(mem_be), 64'b1100);
    chk("sh_wdata", 64'(mem_wdata), 64'h1234_0000);
    drain();

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) store(2'b10, 32'h10 + 32'(4 * k), $urandom);
      chk("full_count", 64'(count), 64'd4);
      chk("full_ready", 64'(st_ready), 64'd0);
      st_valid = 1'b1;
      st_size  = 2'b10;
      st_addr  = 32'h20;
      st_wdata = $urandom;
      tick();
      chk("held_count", 64'(count), 64'd4);
      mem_ready = 1'b1;
      n = 0;
      while (!last_acc && n < 20) begin
        tick();
        n++;
      end
      chk("fifth_accept", 64'(last_acc), 64'd1);
      st_valid = 1'b0;
      drain();
    end

    store(2'b10, 32'h3000, 32'hDEAD_BEEF);
    ld_addr = 32'h3002;
    ld_be   = 4'b0100;
    #1 chk("hz_hit", 64'(ld_hazard), 64'd1);
    ld_addr = 32'h3004;
    #1 chk("hz_other_line", 64'(ld_hazard), 64'd0);
    drain();
    ld_addr = 32'h3002;
    #1 chk("hz_after_drain", 64'(ld_hazard), 64'd0);

    for (int i = 0; i < 400; i++) begin
      st_valid  = 1'($urandom_range(0, 1));
      st_size   = 2'($urandom_range(0, 3));
      st_addr   = 32'h4000 + 32'($urandom_range(0, 31));
      st_wdata  = $urandom;
      mem_ready = ($urandom_range(0, 2) != 0);
      ld_addr   = 32'h4000 + 32'($urandom_range(0, 31));
      ld_be     = 4'($urandom_range(0, 15));
      tick();
    end
    st_valid = 1'b0;
    drain();

    for (int k = 0; k < 3; k++) store(2'b10, 32'h5000 + 32'(4 * k), $urandom);
    chk("mid_rst_pre_count", 64'(count), 64'd3);
    ld_addr = 32'h5000;
    ld_be   = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(mem_valid), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_hazard", 64'(ld_hazard), 64'd0);
    q.delete();
    exp_err = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 64'(st_ready), 64'd1);
    check_state();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
Parametrised store path between the MEM stage and data memory. It generates byte enables and lane-aligned write data for byte, half, word and (when DATA_W=64) double stores, and checks alignment. Accepted stores are queued in a small in-order FIFO and drained to memory through a valid/ready handshake. It also flags load-after-store hazards against buffered entries.

Parameters:
DATA_W, 32, memory data width in bits; 32 or 64.
ADDR_W, 32, byte address width.
DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
st_valid  in  1  store request valid.
st_ready  out  1  buffer can accept; equals !full.
st_size  in  2  00 byte, 01 half, 10 word, 11 dword.
st_addr  in  ADDR_W  byte address of store.
st_wdata  in  DATA_W  store data, right-justified (low bytes significant).
st_align_err  out  1  one-cycle pulse: last consumed request was misaligned or illegal.
mem_valid  out  1  head entry valid.
mem_ready  in  1  memory accepts head entry.
mem_addr  out  ADDR_W  st_addr with low log2(DATA_W/8) bits cleared.
mem_be  out  DATA_W/8  byte enables; bit i = byte lane i (little-endian).
mem_wdata  out  DATA_W  lane-shifted data; unselected lanes 0.
ld_addr  in  ADDR_W  current load address.
ld_be  in  DATA_W/8  current load byte enables.
ld_hazard  out  1  load overlaps a buffered store (combinational).
count  out  clog2(DEPTH+1)  number of buffered entries.

Behaviour:
- Reset (async, rst_n=0): all entries invalid, write/read pointers 0, count 0, mem_valid 0, st_align_err 0, ld_hazard 0; st_ready 1 once rst_n is released. Reset mid-drain discards all entries immediately; no partial write is held.
- Offset off = st_addr[log2(DATA_W/8)-1:0].
- Legal/aligned: byte always; half needs off[0]=0; word needs off[1:0]=0; dword only legal when DATA_W=64 and off[2:0]=0. size 11 with DATA_W=32 is illegal.
- Byte enables: byte 1<<off; half 2'b11<<off; word 4'hF<<off; dword all ones.
- wdata: low (size bytes) of st_wdata shifted left by off*8; other lanes 0.
- Handshake in: request consumed when st_valid && st_ready. Aligned: entry {aligned addr, be, wdata} written at that edge; visible on mem_* from the next cycle (1-cycle min latency). Misaligned/illegal: consumed, nothing pushed, st_align_err=1 for exactly the following cycle.
- Handshake out: mem_valid = (count≠0); mem_* show the head entry and remain stable while mem_valid && !mem_ready. Pop on mem_valid && mem_ready.
- Full: st_ready=0 when count=DEPTH; no bypass, so a pop in the same cycle does not enable a push. st_ready rises the cycle after the pop.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- Empty: no bypass; a push into an empty buffer shows mem_valid=1 on the next cycle.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH; count disambiguates full from empty.
- Hazard: ld_hazard=1 iff some valid entry has mem_addr equal to ld_addr with low bits cleared and (entry be & ld_be)≠0. Only registered entries are checked; the request being accepted in the same cycle is not.
- Ordering: strict FIFO, no merging, no reordering.

Decomposition:
- Package dmem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_DWORD, function for lane-count log2.
- Sub-module store_lane_align (combinational): inputs size and offset, outputs be, shifted wdata and misaligned flag. The FIFO, pointers, count, handshake and hazard compare live in dmem_store_buffer.

Test Plan:
- Reset: hold rst_n=0 → count=0, mem_valid=0, st_align_err=0; release → st_ready=1.
- sb addr 0x1003 data 0x000000AB → next cycle mem_addr 0x1000, mem_be 4'b1000, mem_wdata 0xAB000000.
- sh addr 0x2001 → st_align_err pulses one cycle, count stays 0. Then sh 0x2002 data 0x1234 → mem_be 4'b1100, mem_wdata 0x12340000.
- Full/wrap: mem_ready=0, push 4 sw (0x10,0x14,0x18,0x1C) → count=4, st_ready=0, 5th request held. Set mem_ready=1 → drained in order 0x10..0x1C, then the 5th is accepted; repeat 3 times to exercise pointer wrap.
- Hazard: buffered sw 0x3000 → ld_addr 0x3002 ld_be 4'b0100 gives ld_hazard=1; ld_addr 0x3004 gives 0; after drain, 0x3002 gives 0.
- Mid-operation reset: 3 entries buffered, mem_ready=0, assert rst_n=0 between edges → mem_valid=0 and count=0 without waiting for a clock edge.
